// File: rtl/nn_argmax.sv
// Argmax over the output-layer activation RAM: on a req_i rising edge, read every
// class word in turn and report the index/value of the largest signed activation.
module nn_argmax #(
    parameter int DataWidth  = 8,
    parameter int NumClasses = 4,
    parameter int AddrWidth  = (NumClasses > 1) ? $clog2(NumClasses) : 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic                 req_i,
    output logic                 ack_o,
    output logic [AddrWidth-1:0] ram_addr_o,
    output logic                 ram_we_o,
    input  logic [DataWidth-1:0] ram_dout_i,
    output logic                 busy_o,
    output logic                 valid_o,
    output logic [AddrWidth-1:0] class_o,
    output logic [DataWidth-1:0] max_o
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_e;

    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(NumClasses - 1);

    state_e                 state_q, state_d;
    logic                   req_q;
    logic [AddrWidth-1:0]   addr_q, addr_d;
    logic                   rd_vld_q, rd_vld_d;
    logic [AddrWidth-1:0]   rd_idx_q, rd_idx_d;
    logic signed [DataWidth-1:0] best_q, best_d;
    logic [AddrWidth-1:0]   best_idx_q, best_idx_d;
    logic                   ack_q, ack_d;
    logic                   busy_q, busy_d;
    logic                   valid_q, valid_d;
    logic [AddrWidth-1:0]   class_q, class_d;
    logic signed [DataWidth-1:0] max_q, max_d;

    logic signed [DataWidth-1:0] dout_s;
    logic                   take;
    logic signed [DataWidth-1:0] cand_max;
    logic [AddrWidth-1:0]   cand_idx;

    assign dout_s = ram_dout_i;

    always_comb begin
        // Word for rd_idx_q lands this cycle; index 0 seeds the running max.
        take     = rd_vld_q && ((rd_idx_q == '0) || (dout_s > best_q));
        cand_max = take ? dout_s : best_q;
        cand_idx = take ? rd_idx_q : best_idx_q;

        state_d    = state_q;
        addr_d     = addr_q;
        rd_vld_d   = 1'b0;
        rd_idx_d   = addr_q;
        best_d     = cand_max;
        best_idx_d = cand_idx;
        ack_d      = 1'b0;
        busy_d     = busy_q;
        valid_d    = valid_q;
        class_d    = class_q;
        max_d      = max_q;

        case (state_q)
            IDLE: begin
                addr_d = '0;
                if (req_i && !req_q) begin
                    state_d = SCAN;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                rd_vld_d = 1'b1;
                if (addr_q == LastAddr) begin
                    state_d = DRAIN;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + AddrWidth'(1);
                end
            end
            DRAIN: begin
                // Last word is compared here and published directly, so the
                // result registers update on the same edge that raises ack.
                state_d = DONE;
                ack_d   = 1'b1;
                valid_d = 1'b1;
                class_d = cand_idx;
                max_d   = cand_max;
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            addr_q     <= '0;
            rd_vld_q   <= 1'b0;
            rd_idx_q   <= '0;
            best_q     <= '0;
            best_idx_q <= '0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            class_q    <= '0;
            max_q      <= '0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_i;
            addr_q     <= addr_d;
            rd_vld_q   <= rd_vld_d;
            rd_idx_q   <= rd_idx_d;
            best_q     <= best_d;
            best_idx_q <= best_idx_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            valid_q    <= valid_d;
            class_q    <= class_d;
            max_q      <= max_d;
        end
    end

    assign ack_o      = ack_q;
    assign busy_o     = busy_q;
    assign valid_o    = valid_q;
    assign class_o    = class_q;
    assign max_o      = max_q;
    assign ram_addr_o = addr_q;
    assign ram_we_o   = 1'b0;

endmodule
